// File: rtl/mem_req_unit_pkg.sv
// Shared encodings for the data-side memory request unit: FSM states, access sizes,
// lane-flag bit positions (as decoded by the memory stage) and small helpers.
package mem_req_unit_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

  localparam int unsigned LF_SIGNED  = 32'd4;
  localparam int unsigned LF_BYTE    = 32'd3;
  localparam int unsigned LF_HALF    = 32'd2;
  localparam int unsigned LF_LANE_HI = 32'd1;
  localparam int unsigned LF_LANE_LO = 32'd0;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [4:0]  lane_flag;
  } mem_req_t;

  // The reserved size encoding behaves exactly like a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    logic [1:0] res;
    if (size == 2'd3) begin
      res = MEM_SIZE_WORD;
    end else begin
      res = size;
    end
    return res;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      MEM_SIZE_BYTE: mis = 1'b0;
      MEM_SIZE_HALF: mis = addr_lo[0];
      default:       mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_req_unit_lane_gen.sv
// Combinational lane generation: byte strobes, lane-replicated store data and the
// lane flag handed to the memory stage for load extraction/extension.
module mem_lane_gen
  import mem_req_unit_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        wr,
  input  logic        sgn,
  input  logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rep,
  output logic [4:0]  lane_flag
);

  logic [3:0] strb_s;

  // Shifted strobes are truncated to four lanes, so a misaligned half at lane 3 keeps only lane 3.
  always_comb begin
    strb_s    = 4'b1111;
    wdata_rep = wdata;
    lane_flag = 5'b00000;
    case (size)
      MEM_SIZE_BYTE: begin
        strb_s                            = 4'b0001 << addr_lo;
        wdata_rep                         = {4{wdata[7:0]}};
        lane_flag[LF_SIGNED]              = sgn & ~wr;
        lane_flag[LF_BYTE]                = 1'b1;
        lane_flag[LF_LANE_HI:LF_LANE_LO]  = addr_lo;
      end
      MEM_SIZE_HALF: begin
        strb_s                            = 4'b0011 << addr_lo;
        wdata_rep                         = {2{wdata[15:0]}};
        lane_flag[LF_SIGNED]              = sgn & ~wr;
        lane_flag[LF_HALF]                = 1'b1;
        lane_flag[LF_LANE_HI:LF_LANE_LO]  = addr_lo;
      end
      default: begin
        strb_s    = 4'b1111;
        wdata_rep = wdata;
        lane_flag = 5'b00000;
      end
    endcase
    wstrb = wr ? strb_s : 4'b0000;
  end

endmodule

// File: rtl/mem_req_unit.sv
// Data-side memory request unit between EX and the SRAM-like data bus.
// Define MEM_REQ_ALE_CHECK_EN to enable the alignment check and ale_excp.
module mem_req_unit
  import mem_req_unit_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic        op_wr,
  input  logic [1:0]  op_size,
  input  logic        op_signed,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  input  logic        flush,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [31:0] data_sram_addr,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_lane_flag,
  output logic        ale_excp
);

  logic [1:0]  state_r;
  logic [1:0]  state_nxt_s;
  mem_req_t    req_r;
  mem_req_t    req_nxt_s;
  logic        ale_r;
  logic        accept_s;
  logic        misaligned_s;
  logic        issue_s;
  logic [1:0]  size_s;
  logic [3:0]  wstrb_s;
  logic [31:0] wdata_rep_s;
  logic [4:0]  lane_flag_s;

  assign size_s   = norm_size(op_size);
  assign op_ready = (state_r == ST_IDLE) & ~flush;
  assign accept_s = op_valid & op_ready;

`ifdef MEM_REQ_ALE_CHECK_EN
  assign misaligned_s = is_misaligned(size_s, op_addr[1:0]);
`else
  assign misaligned_s = 1'b0;
`endif

  assign issue_s = accept_s & ~misaligned_s;

  mem_lane_gen u_lane_gen (
    .size      (size_s),
    .addr_lo   (op_addr[1:0]),
    .wr        (op_wr),
    .sgn       (op_signed),
    .wdata     (op_wdata),
    .wstrb     (wstrb_s),
    .wdata_rep (wdata_rep_s),
    .lane_flag (lane_flag_s)
  );

  // Captured request fields; held stable for the whole access.
  always_comb begin
    req_nxt_s = req_r;
    if (issue_s) begin
      req_nxt_s.wr        = op_wr;
      req_nxt_s.size      = size_s;
      req_nxt_s.addr      = op_addr;
      req_nxt_s.wstrb     = wstrb_s;
      req_nxt_s.wdata     = wdata_rep_s;
      req_nxt_s.lane_flag = lane_flag_s;
    end else begin
      req_nxt_s = req_r;
    end
  end

  // Bus protocol: flush withdraws an unaccepted request and drains an accepted one.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (issue_s) begin
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (data_sram_addr_ok) begin
          state_nxt_s = flush ? ST_DROP : ST_WAIT;
        end else if (flush) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (data_sram_data_ok) begin
          state_nxt_s = ST_IDLE;
        end else if (flush) begin
          state_nxt_s = ST_DROP;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_DROP: begin
        if (data_sram_data_ok) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DROP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, captured fields and the alignment-exception pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
      req_r   <= '0;
      ale_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      req_r   <= req_nxt_s;
      ale_r   <= accept_s & misaligned_s;
    end
  end

  assign data_sram_req   = (state_r == ST_REQ);
  assign data_sram_wr    = req_r.wr;
  assign data_sram_size  = req_r.size;
  assign data_sram_addr  = req_r.addr;
  assign data_sram_wstrb = req_r.wstrb;
  assign data_sram_wdata = req_r.wdata;

  // Completion follows data_ok in the same cycle; a concurrent flush kills it.
  assign resp_valid     = (state_r == ST_WAIT) & data_sram_data_ok & ~flush;
  assign resp_rdata     = resp_valid ? data_sram_rdata : 32'h0000_0000;
  assign resp_lane_flag = req_r.lane_flag;
  assign ale_excp       = ale_r;

endmodule

// File: tb/tb_mem_req_unit.sv
// Self-checking bench for mem_req_unit: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_mem_req_unit;

  logic        clk = 1'b0;
  logic        resetn, op_valid, op_wr, op_signed, flush, addr_ok, data_ok;
  logic [1:0]  op_size;
  logic [31:0] op_addr, op_wdata, rdata;
  logic        op_ready, sram_req, sram_wr, resp_valid, ale_excp;
  logic [1:0]  sram_size;
  logic [31:0] sram_addr, sram_wdata, resp_rdata;
  logic [3:0]  sram_wstrb;
  logic [4:0]  resp_lane_flag;

  int checks = 0;
  int errors = 0;

`ifdef MEM_REQ_ALE_CHECK_EN
  localparam bit ALE_ON = 1'b1;
`else
  localparam bit ALE_ON = 1'b0;
`endif

  mem_req_unit dut (
    .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_ready(op_ready), .op_wr(op_wr),
    .op_size(op_size), .op_signed(op_signed), .op_addr(op_addr), .op_wdata(op_wdata),
    .flush(flush), .data_sram_req(sram_req), .data_sram_wr(sram_wr),
    .data_sram_size(sram_size), .data_sram_addr(sram_addr), .data_sram_wstrb(sram_wstrb),
    .data_sram_wdata(sram_wdata), .data_sram_addr_ok(addr_ok), .data_sram_data_ok(data_ok),
    .data_sram_rdata(rdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_lane_flag(resp_lane_flag), .ale_excp(ale_excp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit          m_req, m_bus, m_live, m_ale;
  logic        m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  logic [4:0]  m_flag;

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : ((s == 2'd1) ? 2 : 4);
  endfunction

  function automatic logic [3:0] exp_strb(input logic wr, input logic [1:0] s, input logic [1:0] a);
    logic [3:0] r;
    int nb;
    nb = nbytes(s);
    r = 4'b0000;
    for (int i = 0; i < 4; i++)
      r[i] = wr && ((nb == 4) || (i >= int'(a) && i < int'(a) + nb));
    return r;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] s, input logic [31:0] wd);
    logic [31:0] r;
    int nb;
    nb = nbytes(s);
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = wd[(i % nb)*8 +: 8];
    return r;
  endfunction

  function automatic logic [4:0] exp_flag(input logic wr, input logic sg, input logic [1:0] s,
                                          input logic [1:0] a);
    int nb;
    nb = nbytes(s);
    return {sg && !wr && nb != 4, nb == 1, nb == 2, (nb == 4) ? 2'b00 : a};
  endfunction

  task automatic m_reset();
    m_req = 0; m_bus = 0; m_live = 0; m_ale = 0;
    m_wr = 0; m_size = 0; m_addr = 0; m_wdata = 0; m_wstrb = 0; m_flag = 0;
  endtask

  // Compare at negedge, advance the model at posedge.
  initial begin
    logic [1:0] ns;
    bit exp_resp;
    m_reset();
    forever begin
      @(negedge clk);
      if (!resetn) begin
        m_reset();
        chk("rst_addr", sram_addr, 32'h0);
        chk("rst_wdata", sram_wdata, 32'h0);
        chk("rst_wstrb", {28'h0, sram_wstrb}, 32'h0);
        chk("rst_size", {30'h0, sram_size}, 32'h0);
        chk("rst_flag", {27'h0, resp_lane_flag}, 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
      end
      chk("op_ready", {31'h0, op_ready}, {31'h0, (!m_req && !m_bus && !flush)});
      chk("req", {31'h0, sram_req}, {31'h0, m_req});
      chk("ale_excp", {31'h0, ale_excp}, {31'h0, m_ale});
      exp_resp = m_bus && m_live && data_ok && !flush;
      chk("resp_valid", {31'h0, resp_valid}, {31'h0, exp_resp});
      if (m_req) begin
        chk("addr", sram_addr, m_addr);
        chk("wr", {31'h0, sram_wr}, {31'h0, m_wr});
        chk("size", {30'h0, sram_size}, {30'h0, m_size});
        chk("wstrb", {28'h0, sram_wstrb}, {28'h0, m_wstrb});
        chk("wdata", sram_wdata, m_wdata);
      end
      if (exp_resp) begin
        chk("resp_rdata", resp_rdata, rdata);
        chk("lane_flag", {27'h0, resp_lane_flag}, {27'h0, m_flag});
      end
      @(posedge clk);
      if (!resetn) begin
        m_reset();
      end else begin
        m_ale = 0;
        if (!m_req && !m_bus) begin
          if (op_valid && !flush) begin
            ns = (op_size == 2'd3) ? 2'd2 : op_size;
            if (ALE_ON && (int'(op_addr[1:0]) % nbytes(ns)) != 0) begin
              m_ale = 1;
            end else begin
              m_req = 1; m_wr = op_wr; m_size = ns; m_addr = op_addr;
              m_wstrb = exp_strb(op_wr, ns, op_addr[1:0]);
              m_wdata = exp_wdata(ns, op_wdata);
              m_flag  = exp_flag(op_wr, op_signed, ns, op_addr[1:0]);
            end
          end
        end else if (m_req) begin
          if (addr_ok) begin
            m_req = 0; m_bus = 1; m_live = !flush;
          end else if (flush) begin
            m_req = 0;
          end
        end else begin
          if (data_ok) m_bus = 0;
          else if (flush) m_live = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic wr, input logic [1:0] s, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
    op_valid = 1'b1; op_wr = wr; op_size = s; op_signed = sg; op_addr = a; op_wdata = wd;
  endtask

  initial begin
    bit   bus_out;
    int   dly;
    logic req_seen;
    resetn = 1'b0; op_valid = 1'b0; op_wr = 1'b0; op_size = 2'd0; op_signed = 1'b0;
    op_addr = 32'h0; op_wdata = 32'h0; flush = 1'b0; addr_ok = 1'b0; data_ok = 1'b0;
    rdata = 32'h0;
    step(); step();
    chk("d0_req_in_reset", {31'h0, sram_req}, 32'h0);
    resetn = 1'b1; #1;
    chk("d0_ready", {31'h0, op_ready}, 32'h1);

    // Store byte at lane 3.
    step(); set_op(1'b1, 2'd0, 1'b0, 32'h1C00_0003, 32'h1234_5678); #1;
    chk("d1_ready", {31'h0, op_ready}, 32'h1);
    step(); op_valid = 1'b0; addr_ok = 1'b1; #1;
    chk("d1_req", {31'h0, sram_req}, 32'h1);
    chk("d1_wstrb", {28'h0, sram_wstrb}, 32'h8);
    chk("d1_wdata", sram_wdata, 32'h7878_7878);
    chk("d1_size", {30'h0, sram_size}, 32'h0);
    step(); addr_ok = 1'b0; #1;
    chk("d1_req_off", {31'h0, sram_req}, 32'h0);
    chk("d1_no_resp", {31'h0, resp_valid}, 32'h0);
    step(); data_ok = 1'b1; #1;
    chk("d1_resp", {31'h0, resp_valid}, 32'h1);
    step(); data_ok = 1'b0; #1;
    chk("d1_ready_after", {31'h0, op_ready}, 32'h1);

    // Signed half load at lane 2.
    set_op(1'b0, 2'd1, 1'b1, 32'h1C00_0002, 32'h0);
    step(); op_valid = 1'b0; addr_ok = 1'b1; #1;
    chk("d2_size", {30'h0, sram_size}, 32'h1);
    chk("d2_wstrb", {28'h0, sram_wstrb}, 32'h0);
    step(); addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'hABCD_0000; #1;
    chk("d2_resp", {31'h0, resp_valid}, 32'h1);
    chk("d2_rdata", resp_rdata, 32'hABCD_0000);
    chk("d2_flag", {27'h0, resp_lane_flag}, 32'h16);
    step(); data_ok = 1'b0; op_signed = 1'b0;

    // Misaligned word load.
    set_op(1'b0, 2'd2, 1'b0, 32'h1C00_0006, 32'h0);
    step(); op_valid = 1'b0; #1;
`ifdef MEM_REQ_ALE_CHECK_EN
    chk("d3_ale", {31'h0, ale_excp}, 32'h1);
    chk("d3_no_req", {31'h0, sram_req}, 32'h0);
    step(); #1;
    chk("d3_ale_off", {31'h0, ale_excp}, 32'h0);
    chk("d3_no_req2", {31'h0, sram_req}, 32'h0);
`else
    chk("d3_req", {31'h0, sram_req}, 32'h1);
    chk("d3_addr", sram_addr, 32'h1C00_0006);
    chk("d3_no_ale", {31'h0, ale_excp}, 32'h0);
    addr_ok = 1'b1;
    step(); addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h0102_0304; #1;
    chk("d3_resp", {31'h0, resp_valid}, 32'h1);
    step(); data_ok = 1'b0;
`endif

    // Flush while addr_ok is stalled.
    step(); set_op(1'b1, 2'd2, 1'b0, 32'h1C00_0010, 32'hCAFE_F00D);
    step(); op_valid = 1'b0; #1;
    chk("d4_req1", {31'h0, sram_req}, 32'h1);
    step(); flush = 1'b1; #1;
    chk("d4_req2", {31'h0, sram_req}, 32'h1);
    chk("d4_ready_flush", {31'h0, op_ready}, 32'h0);
    step(); flush = 1'b0; #1;
    chk("d4_withdrawn", {31'h0, sram_req}, 32'h0);
    chk("d4_ready", {31'h0, op_ready}, 32'h1);

    // Flush while waiting for data: response is drained.
    set_op(1'b0, 2'd0, 1'b1, 32'h1C00_0021, 32'h0);
    step(); op_valid = 1'b0; addr_ok = 1'b1;
    step(); addr_ok = 1'b0; flush = 1'b1;
    step(); flush = 1'b0; #1;
    chk("d5_drop_busy", {31'h0, op_ready}, 32'h0);
    step(); data_ok = 1'b1; rdata = 32'h5555_AAAA; #1;
    chk("d5_no_resp", {31'h0, resp_valid}, 32'h0);
    step(); data_ok = 1'b0; #1;
    chk("d5_ready", {31'h0, op_ready}, 32'h1);

    // Reset during WAIT.
    set_op(1'b1, 2'd1, 1'b0, 32'h1C00_0040, 32'h0000_BEEF);
    step(); op_valid = 1'b0; addr_ok = 1'b1;
    step(); addr_ok = 1'b0; #2; resetn = 1'b0; #1;
    chk("d6_req", {31'h0, sram_req}, 32'h0);
    chk("d6_addr", sram_addr, 32'h0);
    chk("d6_wstrb", {28'h0, sram_wstrb}, 32'h0);
    step(); resetn = 1'b1; #1;
    chk("d6_ready", {31'h0, op_ready}, 32'h1);
    chk("d6_resp", {31'h0, resp_valid}, 32'h0);

    // Randomized traffic with a well-behaved bus.
    bus_out = 0; dly = 0; req_seen = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      step();
      if (data_ok) bus_out = 0;
      if (req_seen && addr_ok) begin
        bus_out = 1;
        dly = $urandom_range(0, 3);
      end
      if (!resetn) begin
        resetn = 1'b1;
      end else if ($urandom_range(0, 249) == 0) begin
        resetn = 1'b0;
        bus_out = 0;
      end
      #1;
      req_seen  = resetn ? sram_req : 1'b0;
      flush     = ($urandom_range(0, 9) == 0);
      op_valid  = $urandom_range(0, 1);
      op_wr     = $urandom_range(0, 1);
      op_size   = 2'($urandom_range(0, 3));
      op_signed = $urandom_range(0, 1);
      op_addr   = $urandom;
      op_wdata  = $urandom;
      rdata     = $urandom;
      addr_ok   = req_seen && ($urandom_range(0, 2) != 0);
      if (bus_out && resetn) begin
        if (dly == 0) begin
          data_ok = 1'b1;
        end else begin
          dly--;
          data_ok = 1'b0;
        end
      end else begin
        data_ok = 1'b0;
      end
    end
    step();
    op_valid = 1'b0; flush = 1'b0; addr_ok = 1'b0; data_ok = 1'b0;
    @(negedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
